// File: rtl/afifo_pkg.sv
// afifo_pkg: pointer-code helpers and default geometry shared by both FIFO controllers.
// The Gray/binary converters work on 32-bit zero-extended vectors, so one function
// serves any pointer width up to 32 bits; callers slice the low bits they need.
package afifo_pkg;
    localparam int ADDR_WIDTH = 4;
    localparam int PTR_W      = ADDR_WIDTH + 1;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int FN_W       = 32;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b = g;
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
endpackage

// File: rtl/afifo_rd_obuf.sv
// afifo_rd_obuf: 2-entry first-word-fall-through buffer in front of the synchronous-read RAM.
// Only built when AFIFO_RD_FWFT_EN is defined; it tracks one outstanding RAM read
// (inflight) and only asks for another word when the buffer cannot overflow.
`ifdef AFIFO_RD_FWFT_EN
module afifo_rd_obuf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fetch_i,
    input  logic                  rd_en_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  can_fetch_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]            occ_q, occ_d, base;
    logic                  inflight_q, pop;

    // Pop the head, then append the word returning from the RAM behind what remains.
    always_comb begin
        pop         = rd_en_i & (occ_q != 2'd0);
        base        = occ_q - {1'b0, pop};
        can_fetch_o = (base + {1'b0, inflight_q}) < 2'd2;
        occ_d       = base + {1'b0, inflight_q};
        head_d      = pop ? tail_q : head_q;
        tail_d      = tail_q;
        if (inflight_q) begin
            if (base == 2'd0) head_d = ram_data_i;
            else tail_d = ram_data_i;
        end
    end

    // Buffer storage and occupancy; reset discards buffered and in-flight words.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= fetch_i;
        end
    end

    assign rd_valid_o = occ_q != 2'd0;
    assign rd_data_o  = head_q;
endmodule
`endif

// File: rtl/afifo_rd_ctrl.sv
// afifo_rd_ctrl: read-domain controller of the dual-clock FIFO (pointer, RAM strobe, flags).
// Define AFIFO_RD_FWFT_EN for first-word-fall-through output through afifo_rd_obuf;
// otherwise rd_data is the RAM output with one cycle of latency behind the read strobe.
module afifo_rd_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wrsync_ptr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  ram_rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow
);
    import afifo_pkg::*;

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rd_bin_q, rd_bin_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic          empty_q, empty_d, aempty_q, aempty_d, uf_q, uf_d;
    logic [31:0]   gray_w, wbin_w;
    logic          unused_hi;

    // Next pointer after this cycle's fetch; flags are judged against it so a read of
    // the last word raises empty on the same edge, and a coincident write lands too.
    always_comb begin
        rd_bin_d = rd_bin_q + PW'(ram_rd_en);
        gray_w   = bin2gray(32'(rd_bin_d));
        wbin_w   = gray2bin(32'(wrsync_ptr));
        rd_ptr_d = gray_w[PW-1:0];
        level_d  = wbin_w[PW-1:0] - rd_bin_d;
        empty_d  = rd_ptr_d == wrsync_ptr;
        aempty_d = level_d <= PW'(AEMPTY_THRESH);
    end

    assign unused_hi = ^{gray_w[31:PW], wbin_w[31:PW]};

`ifdef AFIFO_RD_FWFT_EN
    logic can_fetch;

    assign ram_rd_en = ~empty_q & can_fetch;
    assign uf_d      = rd_en & ~rd_valid;

    afifo_rd_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk_i      (rd_clk),
        .rst_i      (rd_rst),
        .fetch_i    (ram_rd_en),
        .rd_en_i    (rd_en),
        .ram_data_i (ram_rd_data),
        .can_fetch_o(can_fetch),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data)
    );
`else
    logic valid_q;

    assign ram_rd_en = rd_en & ~empty_q;
    assign uf_d      = rd_en & empty_q;
    assign rd_data   = ram_rd_data;
    assign rd_valid  = valid_q;

    // RAM data qualifier: the word requested last cycle is on ram_rd_data now.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) valid_q <= 1'b0;
        else valid_q <= ram_rd_en;
    end
`endif

    // Binary and Gray pointers advance together, so the exported Gray never lags.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_bin_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            uf_q     <= 1'b0;
        end else begin
            rd_bin_q <= rd_bin_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            uf_q     <= uf_d;
        end
    end

    assign rd_ptr       = rd_ptr_q;
    assign rd_addr      = rd_bin_q[ADDR_WIDTH-1:0];
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign rd_level     = level_q;
    assign underflow    = uf_q;
endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// tb_afifo_rd_ctrl: randomized self-checking bench; the reference counts words written and read.
module tb_afifo_rd_ctrl;
    logic       rd_clk = 1'b0;
    logic       rd_rst = 1'b1;
    logic       rd_en = 1'b0;
    logic [4:0] wrsync_ptr = '0;
    logic [7:0] ram_rd_data = '0;
    logic [4:0] rd_ptr, rd_level;
    logic [3:0] rd_addr;
    logic       ram_rd_en, rd_valid, empty, almost_empty, underflow;
    logic [7:0] rd_data;

    logic [7:0] mem [16];
    logic [7:0] wq [$];
    int         checks = 0;
    int         fails = 0;
    int         m_r = 0;
    int         m_w = 0;
    logic       x_fetch;
    logic [3:0] x_addr;
    logic       e_empty = 1'b1, e_aempty = 1'b1, e_valid = 1'b0, e_uf = 1'b0;
    logic [4:0] e_level = '0, e_ptr = '0;
    logic [7:0] e_data = '0;

    afifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AEMPTY_THRESH(2)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .wrsync_ptr(wrsync_ptr),
        .ram_rd_data(ram_rd_data), .rd_ptr(rd_ptr), .rd_addr(rd_addr), .ram_rd_en(ram_rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
        .rd_level(rd_level), .underflow(underflow)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) if (ram_rd_en) ram_rd_data <= mem[rd_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [13:0] obs();
        return {empty, almost_empty, rd_level, rd_ptr, rd_valid, underflow};
    endfunction

    function automatic logic [13:0] expv();
        return {e_empty, e_aempty, e_level, e_ptr, e_valid, e_uf};
    endfunction

    task automatic write_word(input logic [7:0] d);
        mem[4'(m_w % 16)] = d;
        wq.push_back(d);
        m_w++;
        wrsync_ptr = gray(m_w);
    endtask

    task automatic model_reset();
        m_r = 0;
        m_w = 0;
        wq.delete();
        wrsync_ptr = '0;
        rd_en = 1'b0;
        {e_empty, e_aempty, e_level, e_ptr, e_valid, e_uf} = {1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0};
    endtask

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rst = 1'b1;
        model_reset();
        @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    task automatic pre(input bit r);
        rd_en   = r;
        x_fetch = r && !e_empty;
        x_addr  = 4'(m_r % 16);
        e_uf    = r && e_empty;
        e_valid = x_fetch;
        if (x_fetch) begin
            e_data = wq.pop_front();
            m_r++;
        end
        e_level  = 5'(m_w - m_r);
        e_empty  = (m_w == m_r);
        e_aempty = (m_w - m_r) <= 2;
        e_ptr    = gray(m_r);
        #1;
    endtask

    task automatic tick();
        @(posedge rd_clk);
        @(negedge rd_clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== {1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got %h want %h", obs(), {1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            pre(1'b1);
            checks++;
            if (ram_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL empty_rd_en: got %b want 0", ram_rd_en);
            end
            tick();
            checks++;
            if ({underflow, empty, rd_ptr} !== {1'b1, 1'b1, 5'd0}) begin
                fails++;
                $display("FAIL empty_underflow: got %b want %b", {underflow, empty, rd_ptr}, {1'b1, 1'b1, 5'd0});
            end
        end
    endtask

`ifndef AFIFO_RD_FWFT_EN
    task automatic test_levels();
        for (int i = 0; i < 5; i++) write_word(8'($urandom));
        pre(1'b0);
        tick();
        checks++;
        if ({rd_level, almost_empty, empty} !== {5'd5, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL level5: got %b want %b", {rd_level, almost_empty, empty}, {5'd5, 1'b0, 1'b0});
        end
        for (int i = 0; i < 5; i++) begin
            pre(1'b1);
            checks++;
            if ({ram_rd_en, rd_addr} !== {x_fetch, x_addr}) begin
                fails++;
                $display("FAIL levels_fetch: got %b want %b", {ram_rd_en, rd_addr}, {x_fetch, x_addr});
            end
            tick();
            checks++;
            if (obs() !== expv() || rd_level !== 5'(4 - i) || rd_data !== e_data) begin
                fails++;
                $display("FAIL levels_read%0d: got %h/%h want %h/%h", i, obs(), rd_data, expv(), e_data);
            end
        end
        checks++;
        if ({empty, rd_ptr} !== {1'b1, 5'b00111}) begin
            fails++;
            $display("FAIL levels_end: got %b want %b", {empty, rd_ptr}, {1'b1, 5'b00111});
        end
    endtask

    task automatic test_wrap();
        logic [3:0] wa [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) write_word(8'($urandom));
            pre(1'b0);
            tick();
            for (int i = 0; i < 10; i++) begin
                pre(1'b1);
                tick();
                checks++;
                if (obs() !== expv() || rd_data !== e_data) begin
                    fails++;
                    $display("FAIL wrap_preload: got %h/%h want %h/%h", obs(), rd_data, expv(), e_data);
                end
            end
        end
        for (int i = 0; i < 4; i++) write_word(8'($urandom));
        pre(1'b0);
        tick();
        checks++;
        if (rd_ptr !== 5'b10001) begin
            fails++;
            $display("FAIL wrap_start_ptr: got %b want 10001", rd_ptr);
        end
        for (int i = 0; i < 4; i++) begin
            pre(1'b1);
            checks++;
            if ({ram_rd_en, rd_addr} !== {1'b1, wa[i]}) begin
                fails++;
                $display("FAIL wrap_addr%0d: got %b want %b", i, {ram_rd_en, rd_addr}, {1'b1, wa[i]});
            end
            tick();
            checks++;
            if (obs() !== expv() || rd_data !== e_data) begin
                fails++;
                $display("FAIL wrap_read%0d: got %h/%h want %h/%h", i, obs(), rd_data, expv(), e_data);
            end
        end
        checks++;
        if ({empty, rd_ptr} !== {1'b1, 5'b00011}) begin
            fails++;
            $display("FAIL wrap_end: got %b want %b", {empty, rd_ptr}, {1'b1, 5'b00011});
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'($urandom));
        pre(1'b0);
        tick();
        checks++;
        if ({rd_level, almost_empty, empty, rd_ptr} !== {5'd16, 1'b0, 1'b0, 5'd0}) begin
            fails++;
            $display("FAIL full_level: got %b want %b", {rd_level, almost_empty, empty, rd_ptr}, {5'd16, 1'b0, 1'b0, 5'd0});
        end
    endtask

    task automatic test_random();
        bit r;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1 && m_w - m_r < 16) write_word(8'($urandom));
            r = $urandom_range(0, 99) < (i < 200 ? 40 : 75);
            pre(r);
            checks++;
            if ({ram_rd_en, rd_addr} !== {x_fetch, x_addr}) begin
                fails++;
                $display("FAIL random_fetch@%0d: got %b want %b", i, {ram_rd_en, rd_addr}, {x_fetch, x_addr});
            end
            tick();
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL random_flags@%0d: got %h want %h", i, obs(), expv());
            end
            if (e_valid) begin
                checks++;
                if (rd_data !== e_data) begin
                    fails++;
                    $display("FAIL random_data@%0d: got %h want %h", i, rd_data, e_data);
                end
            end
        end
    endtask
`endif

    task automatic test_stream();
        logic [7:0] ex [3] = '{8'hA1, 8'hA2, 8'hA3};
        do_reset();
        for (int i = 0; i < 3; i++) write_word(ex[i]);
`ifdef AFIFO_RD_FWFT_EN
        tick();
        checks++;
        if ({empty, rd_valid} !== 2'b00) begin
            fails++;
            $display("FAIL fwft_latency0: got %b want 00", {empty, rd_valid});
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL fwft_latency1: got %b want 0", rd_valid);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b1) begin
            fails++;
            $display("FAIL fwft_latency2: got %b want 1", rd_valid);
        end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            #1;
            checks++;
            if ({rd_valid, underflow, rd_data} !== {1'b1, 1'b0, ex[i]}) begin
                fails++;
                $display("FAIL stream%0d: got %b want %b", i, {rd_valid, underflow, rd_data}, {1'b1, 1'b0, ex[i]});
            end
            tick();
        end
        rd_en = 1'b0;
        #1;
`else
        pre(1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            pre(1'b1);
            tick();
            checks++;
            if ({rd_valid, underflow, rd_data} !== {1'b1, 1'b0, ex[i]}) begin
                fails++;
                $display("FAIL stream%0d: got %b want %b", i, {rd_valid, underflow, rd_data}, {1'b1, 1'b0, ex[i]});
            end
        end
        pre(1'b0);
        tick();
`endif
        checks++;
        if ({rd_valid, underflow, empty} !== 3'b001) begin
            fails++;
            $display("FAIL stream_end: got %b want 001", {rd_valid, underflow, empty});
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        for (int i = 0; i < 3; i++) write_word(8'($urandom));
`ifdef AFIFO_RD_FWFT_EN
        repeat (4) tick();
        rd_en = 1'b1;
`else
        pre(1'b0);
        tick();
        pre(1'b1);
`endif
        @(posedge rd_clk);
        #2;
        rd_rst = 1'b1;
        #1;
        checks++;
        if ({rd_valid, empty, rd_level, almost_empty, underflow} !== {1'b0, 1'b1, 5'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: got %b want %b", {rd_valid, empty, rd_level, almost_empty, underflow},
                     {1'b0, 1'b1, 5'd0, 1'b1, 1'b0});
        end
        @(negedge rd_clk);
        model_reset();
        rd_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pre(1'b0);
            tick();
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL post_reset%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
`ifndef AFIFO_RD_FWFT_EN
        test_levels();
        test_wrap();
        test_full();
        test_random();
`endif
        test_stream();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
